prog_seq_detect_param: RTL and testbench

- Parametrised programmable serial pattern detector: the next generation of the 5-bit programmable sequence detector.
- Matches a runtime-loadable PAT_W-bit pattern on a 1-bit serial stream with a valid qualifier.
- Supports overlapping and non-overlapping match modes, and keeps a saturating match counter.
- Sits on serial input paths (framing/sync-word detection) and feeds a one-cycle match strobe to downstream control.

---
 rtl/prog_seq_pkg.sv | 17 +
 rtl/prog_seq_detect_param_if.sv | 25 ++
 rtl/prog_seq_detect_param_sat_counter.sv | 30 +++
 rtl/prog_seq_detect_param.sv | 66 ++++++
 tb/tb_prog_seq_detect_param.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared mode constants and saturating increment helper
package prog_seq_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Increment value, holding at the largest number representable in width bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    if (width >= 32)
      max_val = '1;
    else
      max_val = (32'd1 << width) - 32'd1;
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/prog_seq_detect_param_if.sv
// rtl/prog_seq_detect_param_if.sv - control, serial and status signals of the pattern detector
interface prog_seq_detect_param_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             din_valid;
  logic             din;
  logic             cnt_clr;
  logic             seen;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output load, pat_in, overlap, din_valid, din, cnt_clr,
    input  seen, match_cnt, armed
  );

  modport slave (
    input  load, pat_in, overlap, din_valid, din, cnt_clr,
    output seen, match_cnt, armed
  );
endinterface

// File: rtl/prog_seq_detect_param_sat_counter.sv
// rtl/prog_seq_detect_param_sat_counter.sv - saturating up-counter with clear
module sat_counter
  import prog_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [31:0] q_inc;

  always_comb begin
    q_inc = sat_inc(32'(q), WIDTH);
  end

  // A clear coinciding with an increment counts the increment after the clear.
  always_ff @(posedge clk) begin
    if (!resetn)
      q <= '0;
    else if (clr)
      q <= inc ? WIDTH'(1) : '0;
    else if (inc)
      q <= q_inc[WIDTH-1:0];
  end

endmodule

// File: rtl/prog_seq_detect_param.sv
// rtl/prog_seq_detect_param.sv - programmable PAT_W-bit serial pattern detector
// with overlap/non-overlap modes and a saturating match counter.
module prog_seq_detect_param
  import prog_seq_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  prog_seq_detect_param_if.slave   bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic              seen_q;
  logic [PAT_W-1:0]  nhist;
  logic [FILL_W-1:0] nfill;
  logic              accept;
  logic              match;

  // Load takes priority over data arriving in the same cycle.
  always_comb begin
    accept = bus.din_valid && !bus.load;
    nhist  = {hist[PAT_W-2:0], bus.din};
    nfill  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    match  = accept && (nfill == FILL_FULL) && (nhist == pat);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pat    <= '0;
      hist   <= '0;
      fill   <= '0;
      seen_q <= 1'b0;
    end else if (bus.load) begin
      pat    <= bus.pat_in;
      hist   <= '0;
      fill   <= '0;
      seen_q <= 1'b0;
    end else if (bus.din_valid) begin
      hist   <= nhist;
      seen_q <= match;
      // Non-overlap mode forces a full fresh pattern before the next match.
      fill   <= (match && (bus.overlap == MODE_NONOVL)) ? '0 : nfill;
    end else begin
      seen_q <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (match),
    .clr    (bus.cnt_clr),
    .q      (bus.match_cnt)
  );

  assign bus.seen  = seen_q;
  assign bus.armed = (fill == FILL_FULL);

endmodule

// File: tb/tb_prog_seq_detect_param.sv
// tb/tb_prog_seq_detect_param.sv - directed self-checking bench for prog_seq_detect_param
module tb_prog_seq_detect_param;

  logic clk = 1'b0;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  prog_seq_detect_param_if #(.PAT_W(5), .CNT_W(8)) ia ();
  prog_seq_detect_param_if #(.PAT_W(5), .CNT_W(2)) ib ();

  prog_seq_detect_param #(.PAT_W(5), .CNT_W(8)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ia.slave)
  );

  prog_seq_detect_param #(.PAT_W(5), .CNT_W(2)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ib.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic ld, input logic [4:0] pin, input logic vld,
                        input logic d, input logic clr);
    ia.load = ld; ia.pat_in = pin; ia.din_valid = vld; ia.din = d; ia.cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic ld, input logic [4:0] pin, input logic vld,
                        input logic d, input logic clr);
    ib.load = ld; ib.pat_in = pin; ib.din_valid = vld; ib.din = d; ib.cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_a(input logic d, input logic exp_seen, input string tag);
    step_a(1'b0, 5'd0, 1'b1, d, 1'b0);
    check(tag, 32'(ia.seen), 32'(exp_seen));
  endtask

  initial begin
    logic [6:0] s7;
    resetn = 1'b0;
    ia.overlap = 1'b1; ib.overlap = 1'b1;
    step_a(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_b(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_seen", 32'(ia.seen), 32'd0);
    check("rst_cnt", 32'(ia.match_cnt), 32'd0);
    check("rst_armed", 32'(ia.armed), 32'd0);
    resetn = 1'b1;

    // Basic match, pattern 10110
    step_a(1'b1, 5'b10110, 1'b0, 1'b0, 1'b0);
    check("ld_armed", 32'(ia.armed), 32'd0);
    bit_a(1'b1, 1'b0, "t1_b1");
    bit_a(1'b0, 1'b0, "t1_b2");
    bit_a(1'b1, 1'b0, "t1_b3");
    bit_a(1'b1, 1'b0, "t1_b4");
    bit_a(1'b0, 1'b1, "t1_b5");
    check("t1_cnt", 32'(ia.match_cnt), 32'd1);
    check("t1_armed", 32'(ia.armed), 32'd1);
    step_a(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("t1_seen_drop", 32'(ia.seen), 32'd0);

    // Overlap on 10101 with stream 1010101
    s7 = 7'b1010101;
    step_a(1'b1, 5'b10101, 1'b0, 1'b0, 1'b1);
    check("t2_clr", 32'(ia.match_cnt), 32'd0);
    for (int i = 0; i < 7; i++)
      bit_a(s7[6-i], (i == 4 || i == 6), $sformatf("t2o_b%0d", i + 1));
    check("t2o_cnt", 32'(ia.match_cnt), 32'd2);

    // Same stream, non-overlap
    ia.overlap = 1'b0;
    step_a(1'b1, 5'b10101, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      bit_a(s7[6-i], (i == 4), $sformatf("t2n_b%0d", i + 1));
      if (i == 4) check("t2n_armed_cleared", 32'(ia.armed), 32'd0);
    end
    check("t2n_cnt", 32'(ia.match_cnt), 32'd1);
    ia.overlap = 1'b1;

    // Gapped stream on 11011
    step_a(1'b1, 5'b11011, 1'b0, 1'b0, 1'b1);
    bit_a(1'b1, 1'b0, "t3_b1");
    bit_a(1'b1, 1'b0, "t3_b2");
    bit_a(1'b0, 1'b0, "t3_b3");
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      check($sformatf("t3_idle%0d", i), 32'(ia.seen), 32'd0);
    end
    bit_a(1'b1, 1'b0, "t3_b4");
    bit_a(1'b1, 1'b1, "t3_b5");
    step_a(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("t3_post_idle", 32'(ia.seen), 32'd0);
    check("t3_cnt", 32'(ia.match_cnt), 32'd1);

    // Mid-stream load of all-zero pattern with valid data present
    step_a(1'b1, 5'b10110, 1'b0, 1'b0, 1'b1);
    bit_a(1'b1, 1'b0, "t4_b1");
    bit_a(1'b0, 1'b0, "t4_b2");
    bit_a(1'b1, 1'b0, "t4_b3");
    bit_a(1'b1, 1'b0, "t4_b4");
    step_a(1'b1, 5'b00000, 1'b1, 1'b0, 1'b0);
    check("t4_ld_seen", 32'(ia.seen), 32'd0);
    check("t4_ld_armed", 32'(ia.armed), 32'd0);
    for (int i = 0; i < 5; i++)
      bit_a(1'b0, (i == 4), $sformatf("t4_z%0d", i + 1));
    check("t4_cnt", 32'(ia.match_cnt), 32'd1);

    // Reset between bit 4 and bit 5
    step_a(1'b1, 5'b10110, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1, 1'b0, "t5_b1");
    bit_a(1'b0, 1'b0, "t5_b2");
    bit_a(1'b1, 1'b0, "t5_b3");
    bit_a(1'b1, 1'b0, "t5_b4");
    resetn = 1'b0;
    step_a(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    resetn = 1'b1;
    check("t5_rst_seen", 32'(ia.seen), 32'd0);
    check("t5_rst_cnt", 32'(ia.match_cnt), 32'd0);
    check("t5_rst_armed", 32'(ia.armed), 32'd0);
    // Reset pattern is zero: five zeros match without a load
    for (int i = 0; i < 5; i++)
      bit_a(1'b0, (i == 4), $sformatf("t5_z%0d", i + 1));
    step_a(1'b1, 5'b10110, 1'b0, 1'b0, 1'b0);
    bit_a(1'b1, 1'b0, "t5_r1");
    bit_a(1'b0, 1'b0, "t5_r2");
    bit_a(1'b1, 1'b0, "t5_r3");
    bit_a(1'b1, 1'b0, "t5_r4");
    bit_a(1'b0, 1'b1, "t5_r5");
    check("t5_cnt", 32'(ia.match_cnt), 32'd2);
    step_a(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Saturation with CNT_W=2
    step_b(1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step_b(1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      check($sformatf("t6_seen%0d", i + 1), 32'(ib.seen), 32'(i >= 4));
      check($sformatf("t6_cnt%0d", i + 1), 32'(ib.match_cnt),
            (i < 4) ? 32'd0 : ((i - 3 > 3) ? 32'd3 : 32'(i - 3)));
    end
    step_b(1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    check("t6_clr_match_seen", 32'(ib.seen), 32'd1);
    check("t6_clr_match_cnt", 32'(ib.match_cnt), 32'd1);
    step_b(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("t6_clr_only", 32'(ib.match_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
